// File: rtl/alu_if.sv
// ALU request/response bundle: operands and opcode in, status and result out.
interface alu_if #(
  parameter int DATA_BUS_WIDTH = 8
);
  logic                      start;
  logic [2:0]                alu_op;
  logic [DATA_BUS_WIDTH-1:0] operand_a;
  logic [DATA_BUS_WIDTH-1:0] operand_b;
  logic                      busy;
  logic                      done;
  logic [DATA_BUS_WIDTH-1:0] result;
  logic [2:0]                flags;

  modport master (
    output start, alu_op, operand_a, operand_b,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, alu_op, operand_a, operand_b,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu.sv
// Sequenced ALU: single-cycle add/sub/logic/shift and a W-iteration
// shift-add multiply. Result and Z/N/C flags are registered and change
// only on completion; done pulses for one cycle on every completion.
module alu #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input logic clock,
  input logic reset,
  alu_if.slave bus
);
  localparam int W  = DATA_BUS_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] mcand, mcand_nxt, acc, acc_nxt, acc_add;
  logic [W-1:0]   mplier, mplier_nxt, result, result_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     flags, flags_nxt;
  logic           busy_q, done_q;

  logic [W:0]     sum, diff;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  op_t            op;

  assign op = op_t'(bus.alu_op);

  // Single-cycle datapath on the live operands; carry/borrow/shifted-out bit in alu_c.
  always_comb begin
    sum     = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    diff    = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[W-1:0];  alu_c = sum[W];  end
      OP_SUB: begin alu_res = diff[W-1:0]; alu_c = diff[W]; end
      OP_AND: alu_res = bus.operand_a & bus.operand_b;
      OP_OR:  alu_res = bus.operand_a | bus.operand_b;
      OP_XOR: alu_res = bus.operand_a ^ bus.operand_b;
      OP_SHL: begin alu_res = {bus.operand_a[W-2:0], 1'b0}; alu_c = bus.operand_a[W-1]; end
      OP_SHR: begin alu_res = {1'b0, bus.operand_a[W-1:1]}; alu_c = bus.operand_a[0];   end
      default: begin alu_res = '0; alu_c = 1'b0; end
    endcase
  end

  // One shift-add step: the accumulator including this iteration's partial product.
  assign acc_add = acc + (mplier[0] ? mcand : '0);

  // Next state and datapath updates; everything holds unless the state says otherwise.
  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    result_nxt = result;
    flags_nxt  = flags;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (op == OP_MUL) begin
            mcand_nxt  = {{W{1'b0}}, bus.operand_a};
            mplier_nxt = bus.operand_b;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            state_nxt  = ST_MUL;
          end else begin
            result_nxt = alu_res;
            flags_nxt  = {alu_res == '0, alu_res[W-1], alu_c};
            state_nxt  = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_nxt    = acc_add;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CW'(W - 1)) begin
          result_nxt = acc_add[W-1:0];
          flags_nxt  = {acc_add[W-1:0] == '0, acc_add[W-1], |acc_add[2*W-1:W]};
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; busy/done are registered from next state so outputs come from flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
      flags  <= flags_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= (state_nxt == ST_DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result;
  assign bus.flags  = flags;
endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: vector table for every opcode plus hand-written
// sequences for reset, operand stability, ignored starts and back-to-back issue.
module tb_alu;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_if #(.DATA_BUS_WIDTH(W)) bus_if ();

  alu #(.DATA_BUS_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [2:0] flg;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op, then wait (bounded) for done. lat = edges after the accepting edge.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit busy_ok);
    bus_if.start     = 1'b1;
    bus_if.alu_op    = op;
    bus_if.operand_a = a;
    bus_if.operand_b = b;
    step();
    bus_if.start = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) step();
      if (!bus_if.busy) busy_ok = 1'b0;
      if (bus_if.done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  bok;
    int  ndone;
    logic [7:0] pat;

    bus_if.start     = 1'b0;
    bus_if.alu_op    = 3'd0;
    bus_if.operand_a = 8'h00;
    bus_if.operand_b = 8'h00;

    vecs.push_back('{"add_carry", 3'd0, 8'hF0, 8'h20, 8'h10, 3'b001, 0});
    vecs.push_back('{"add_wrap",  3'd0, 8'h80, 8'h80, 8'h00, 3'b101, 0});
    vecs.push_back('{"sub_borrow",3'd1, 8'h03, 8'h05, 8'hFE, 3'b011, 0});
    vecs.push_back('{"and",       3'd2, 8'hF0, 8'h3C, 8'h30, 3'b000, 0});
    vecs.push_back('{"or",        3'd3, 8'h80, 8'h01, 8'h81, 3'b010, 0});
    vecs.push_back('{"xor_zero",  3'd4, 8'hAA, 8'hAA, 8'h00, 3'b100, 0});
    vecs.push_back('{"shl",       3'd5, 8'h81, 8'h00, 8'h02, 3'b001, 0});
    vecs.push_back('{"shr",       3'd6, 8'h01, 8'h00, 8'h00, 3'b101, 0});
    vecs.push_back('{"mul_0c_0b", 3'd7, 8'h0C, 8'h0B, 8'h84, 3'b010, W});
    vecs.push_back('{"mul_10_10", 3'd7, 8'h10, 8'h10, 8'h00, 3'b101, W});
    vecs.push_back('{"mul_ff_00", 3'd7, 8'hFF, 8'h00, 8'h00, 3'b100, W});
    vecs.push_back('{"mul_ff_ff", 3'd7, 8'hFF, 8'hFF, 8'h01, 3'b001, W});

    // Reset held: outputs at reset values.
    step();
    step();
    chk("rst_result", 32'(bus_if.result), 32'h00);
    chk("rst_flags",  32'(bus_if.flags),  32'h0);
    chk("rst_busy",   32'(bus_if.busy),   32'h0);
    chk("rst_done",   32'(bus_if.done),   32'h0);
    reset = 1'b1;
    step();
    chk("rel_busy", 32'(bus_if.busy), 32'h0);

    // Table of vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      chk({vecs[i].name, "_lat"},    32'(lat),            32'(vecs[i].lat));
      chk({vecs[i].name, "_result"}, 32'(bus_if.result),  32'(vecs[i].res));
      chk({vecs[i].name, "_flags"},  32'(bus_if.flags),   32'(vecs[i].flg));
      chk({vecs[i].name, "_busy"},   32'(bok),            32'h1);
      step();
      chk({vecs[i].name, "_donefall"}, 32'(bus_if.done),  32'h0);
      chk({vecs[i].name, "_hold"},   32'(bus_if.result),  32'(vecs[i].res));
      step();
    end

    // MUL with operand toggling and ignored starts during MUL and DONE.
    bus_if.start     = 1'b1;
    bus_if.alu_op    = 3'd7;
    bus_if.operand_a = 8'h0C;
    bus_if.operand_b = 8'h0B;
    step();
    bus_if.start = 1'b0;
    ndone = 0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      bus_if.operand_a = 8'(i * 37);
      bus_if.operand_b = 8'(i * 91);
      bus_if.alu_op    = 3'd0;
      bus_if.start     = (i == 3);
      step();
      bus_if.start = 1'b0;
      if (bus_if.done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          // Pulse start while in DONE; must be ignored.
          bus_if.start = 1'b1;
          step();
          bus_if.start = 1'b0;
          if (bus_if.done) ndone++;
        end
      end
      if (lat > 0 && i >= lat + 4) break;
    end
    chk("tog_lat",    32'(lat),           32'(W));
    chk("tog_ndone",  32'(ndone),         32'h1);
    chk("tog_result", 32'(bus_if.result), 32'h84);
    chk("tog_flags",  32'(bus_if.flags),  32'b010);
    chk("tog_busy",   32'(bus_if.busy),   32'h0);

    // start held high: single-cycle ops accepted every other cycle.
    bus_if.alu_op    = 3'd0;
    bus_if.operand_a = 8'h01;
    bus_if.operand_b = 8'h02;
    bus_if.start     = 1'b1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      pat[i] = bus_if.done;
    end
    bus_if.start = 1'b0;
    chk("held_pattern", 32'(pat),           32'h55);
    chk("held_result",  32'(bus_if.result), 32'h03);
    step();
    step();

    // Reset in the middle of a MUL: async, no edge needed, no done afterwards.
    run_op(3'd3, 8'h80, 8'h01, lat, bok);
    chk("pre_rst_result", 32'(bus_if.result), 32'h81);
    step();
    step();
    bus_if.start     = 1'b1;
    bus_if.alu_op    = 3'd7;
    bus_if.operand_a = 8'h0C;
    bus_if.operand_b = 8'h0B;
    step();
    bus_if.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_result", 32'(bus_if.result), 32'h00);
    chk("mrst_flags",  32'(bus_if.flags),  32'h0);
    chk("mrst_busy",   32'(bus_if.busy),   32'h0);
    chk("mrst_done",   32'(bus_if.done),   32'h0);
    step();
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_if.done) ndone++;
    end
    chk("mrst_nodone",    32'(ndone),         32'h0);
    chk("mrst_result_after", 32'(bus_if.result), 32'h00);
    chk("mrst_busy_after",   32'(bus_if.busy),   32'h0);
    run_op(3'd0, 8'h01, 8'h01, lat, bok);
    chk("post_add_lat",    32'(lat),           32'h0);
    chk("post_add_result", 32'(bus_if.result), 32'h02);
    chk("post_add_flags",  32'(bus_if.flags),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, checks %0d expected to finish", n_chk);
    $fatal(1);
  end
endmodule

// File: doc/alu.md
# alu

Sequenced arithmetic/logic unit that consumes the two read ports of the register file and produces a result for its write port. Operand A comes from `reg_1_out` and operand B from `reg_2_out`. A one-cycle `done` strobe qualifies `result`; the control path turns that strobe into a `REG_WRITE` of `result` into the selected register. Most operations complete in one cycle. `MUL` is a multi-cycle shift-add that holds `busy` until finished. A flags register (Z, N, C) is kept for the branch logic.

## Interface
- `DATA_BUS_WIDTH`, default 8: operand, result and register width (W below). Must be ≥ 2.
- `clock`  input  1  sole clock; everything changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only while state is IDLE, ignored otherwise.
- `alu_op`  input  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- `operand_a`  input  W  first operand, driven from the register file's `reg_1_out`.
- `operand_b`  input  W  second operand, driven from the register file's `reg_2_out`.
- `busy`  output  1  high whenever state ≠ IDLE.
- `done`  output  1  high for exactly one cycle when `result` and `flags` are new.
- `result`  output  W  registered result; holds its value until the next completion.
- `flags`  output  3  registered flags: bit2 = Z, bit1 = N, bit0 = C.

## Operation
- **States:** IDLE, MUL, DONE. Reset state is IDLE.
- **IDLE with start, alu_op ≠ 7:**
  - Compute from the live operands.
  - Write `result` and `flags`.
  - Go to DONE.
- **IDLE with start, alu_op = 7:**
  - Latch `operand_a` into a 2W-bit multiplicand (zero-extended) and `operand_b` into a W-bit multiplier.
  - Clear the 2W-bit accumulator and the iteration counter.
  - Go to MUL.
- **MUL, each cycle:**
  - If multiplier bit0 is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
  - On the W-th iteration, write `result` = accumulator[W-1:0] (including that iteration's add) and `flags`, then go to DONE.
- **DONE:** `done` = 1, then go to IDLE unconditionally. A `start` seen in DONE is ignored.
- **Operand stability:** operands latched for MUL are not affected by input changes during MUL.
- **Arithmetic rules:** all modulo 2^W. Shifts move by 1 and fill with 0.
- **Z flag:** result == 0.
- **N flag:** result[W-1].
- **C flag, per operation:**
  - ADD: carry-out of a+b.
  - SUB: borrow, i.e. a < b unsigned.
  - SHL: a[W-1].
  - SHR: a[0].
  - AND, OR, XOR: 0.
  - MUL: 1 iff accumulator[2W-1:W] ≠ 0.
- **Hold:** `flags` and `result` change only on completion. They hold at all other times, including through IDLE.
- **Reset, including mid-MUL:**
  - State goes to IDLE; `result`, `flags`, `busy`, `done`, accumulator and counter all go to 0.
  - An aborted MUL never produces `done`.

## Timing
- Reset values: `result` = 0, `flags` = 3'b000, `busy` = 0, `done` = 0.
- Single-cycle ops: `start` sampled at edge k, so `result`, `flags` and `done` are valid after edge k. `done` falls after edge k+1. Latency is 1 cycle.
- MUL: `start` sampled at edge k. Iterations run at edges k+1 … k+W. `done` is high after edge k+W. Latency is W+1 cycles; for W = 8, `done` is high 9 cycles after `start`.
- `busy` is high from edge k until the edge that returns to IDLE, inclusive of the DONE cycle.
- Maximum issue rate: one op every 2 cycles (single-cycle ops), or every W+2 cycles (MUL).
- `start` held high continuously: a new op is accepted on each IDLE cycle.
- No combinational path from any input to any output; all outputs come straight from flops.

## Test plan
- **Reset:** assert `reset` = 0 mid-run → all outputs 0 and state IDLE, with no clock edge required. Release → `busy` = 0.
- **ADD carry:** ADD 0xF0 + 0x20 → after 1 cycle `result` = 0x10, `flags` = 3'b001, `done` high for one cycle. Then ADD 0x80 + 0x80 → `result` = 0x00, `flags` = 3'b101.
- **SUB, logic and shifts:**
  - SUB 0x03 - 0x05 → `result` = 0xFE, `flags` = 3'b011.
  - XOR 0xAA ^ 0xAA → `result` = 0x00, `flags` = 3'b100.
  - SHL 0x81 → `result` = 0x02, C = 1.
  - SHR 0x01 → `result` = 0x00, `flags` = 3'b101.
- **MUL:**
  - MUL 0x0C × 0x0B → `done` exactly 9 cycles after `start`; `result` = 0x84, `flags` = 3'b010; `busy` high the whole time.
  - Toggling the operands mid-MUL has no effect.
  - MUL 0x10 × 0x10 → `result` = 0x00, `flags` = 3'b101.
  - MUL 0xFF × 0x00 → `result` = 0x00, `flags` = 3'b100.
- **Busy handling:** pulse `start` with ADD during MUL and again during DONE → ignored, no extra `done`, MUL result intact. `start` held high continuously → ops accepted every 2 cycles for single-cycle ops.
- **Reset mid-MUL:** pull `reset` low at iteration 4, then release → no `done`, `result`/`flags` = 0. A following ADD 1 + 1 gives `result` = 0x02.
